// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data memory port.
// Registered grant with round-robin tie-break and bounded hold.
module dmem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          beat0, beat1;
   logic          hold_full;

   assign hold_full = (hold_q == HOLD_MAX);

   // State, last-owner and hold counter registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state: tie-break on last, preempt at hold limit, release on req drop
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            if (r0_req && r1_req) state_d = last_q ? OWN0 : OWN1;
            else if (r0_req)      state_d = OWN0;
            else if (r1_req)      state_d = OWN1;
         end
         OWN0: begin
            if (r0_req) begin
               if (hold_full && r1_req) begin
                  state_d = OWN1;
                  last_d  = 1'b0;
                  hold_d  = '0;
               end else if (!hold_full) begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end else begin
               state_d = r1_req ? OWN1 : IDLE;
               last_d  = 1'b0;
               hold_d  = '0;
            end
         end
         OWN1: begin
            if (r1_req) begin
               if (hold_full && r0_req) begin
                  state_d = OWN0;
                  last_d  = 1'b1;
                  hold_d  = '0;
               end else if (!hold_full) begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end else begin
               state_d = r0_req ? OWN0 : IDLE;
               last_d  = 1'b1;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant decode and memory port mux from the owner's live inputs
   always_comb begin
      r0_gnt    = (state_q == OWN0);
      r1_gnt    = (state_q == OWN1);
      owner     = state_q;
      beat0     = r0_gnt & r0_req;
      beat1     = r1_gnt & r1_req;
      mem_rd    = (beat0 & ~r0_we) | (beat1 & ~r1_we);
      mem_wr    = (beat0 & r0_we) | (beat1 & r1_we);
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         beat0: begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
         end
         beat1: begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
         end
         default: ;
      endcase
   end

   // Read return: one-cycle rvalid, rdata held until the next read
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= beat0 & ~r0_we;
         r1_rvalid <= beat1 & ~r1_we;
         if (beat0 & ~r0_we) r0_rdata <= mem_rdata;
         if (beat1 & ~r1_we) r1_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter.
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.AW(32), .DW(32), .MAX_HOLD(4)) dut (
      .CLK       (clk),
      .RESET     (rst_n),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
      mem_rdata = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 1'b0;
      r0_req = 1'b1;
      r1_req = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd, mem_wr, owner}
          !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 00000000",
                  {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd, mem_wr, owner});
      end
      checks++;
      if ({r0_rdata, r1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h want 0",
                  r0_rdata, r1_rdata, mem_addr, mem_wdata);
      end
      do_reset();
   endtask

   task automatic test_r0_read;
      tick();
      r0_req = 1; r0_we = 0; r0_addr = 32'h10;
      #1;
      checks++;
      if ({r0_gnt, mem_rd} !== 2'b00) begin
         errors++;
         $display("FAIL rd_c0_latency: got gnt,rd=%b want 00", {r0_gnt, mem_rd});
      end
      tick();
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, mem_rd, mem_wr, owner} !== 6'b101001) begin
         errors++;
         $display("FAIL rd_c1_ctl: got %b want 101001",
                  {r0_gnt, r1_gnt, mem_rd, mem_wr, owner});
      end
      checks++;
      if (mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL rd_c1_addr: got %h want 00000010", mem_addr);
      end
      tick();
      r0_req = 0;
      mem_rdata = '0;
      #1;
      checks++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL rd_c2_data: got v=%b d=%h want v=1 d=deadbeef",
                  r0_rvalid, r0_rdata);
      end
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rd_drop_noaccess: got rd=%b a=%h want 0 0", mem_rd, mem_addr);
      end
      tick();
      #1;
      checks++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 32'hDEAD_BEEF || owner !== 2'b00) begin
         errors++;
         $display("FAIL rd_c3_hold: got v=%b d=%h o=%b want 0 deadbeef 00",
                  r0_rvalid, r0_rdata, owner);
      end
   endtask

   task automatic test_r1_write;
      tick();
      r1_req = 1; r1_we = 1; r1_addr = 32'h20; r1_wdata = 32'h55;
      #1;
      checks++;
      if (mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL wr_c0: got mem_wr=%b want 0", mem_wr);
      end
      tick();
      #1;
      checks++;
      if ({r1_gnt, r0_gnt, mem_wr, mem_rd, owner} !== 6'b101010) begin
         errors++;
         $display("FAIL wr_c1_ctl: got %b want 101010",
                  {r1_gnt, r0_gnt, mem_wr, mem_rd, owner});
      end
      checks++;
      if (mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin
         errors++;
         $display("FAIL wr_c1_data: got a=%h d=%h want 20 55", mem_addr, mem_wdata);
      end
      tick();
      r1_req = 0;
      #1;
      checks++;
      if ({mem_wr, r1_rvalid} !== 2'b00 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_c2_once: got wr=%b v=%b d=%h want 0 0 0",
                  mem_wr, r1_rvalid, mem_wdata);
      end
      tick();
      #1;
      checks++;
      if (r1_rvalid !== 1'b0 || owner !== 2'b00) begin
         errors++;
         $display("FAIL wr_c3: got v=%b o=%b want 0 00", r1_rvalid, owner);
      end
      r1_we = 0;
   endtask

   task automatic test_handover;
      do_reset();
      tick();
      r0_req = 1; r0_addr = 32'h100;
      r1_req = 1; r1_addr = 32'h200;
      #1;
      for (int c = 1; c <= 2; c++) begin
         tick();
         #1;
         checks++;
         if ({r0_gnt, r1_gnt} !== 2'b10 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL ho_first c%0d: got g=%b a=%h want 10 100",
                     c, {r0_gnt, r1_gnt}, mem_addr);
         end
      end
      tick();
      r0_req = 0;
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, mem_rd} !== 3'b100) begin
         errors++;
         $display("FAIL ho_c3: got g,rd=%b want 100", {r0_gnt, r1_gnt, mem_rd});
      end
      tick();
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, owner} !== 4'b0110 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL ho_c4: got g,o=%b a=%h want 0110 200",
                  {r0_gnt, r1_gnt, owner}, mem_addr);
      end
      r1_req = 0;
      tick();
      tick();
   endtask

   task automatic test_hold_limit;
      logic [1:0]  exp_o;
      logic [31:0] exp_a;
      do_reset();
      tick();
      r0_req = 1; r0_addr = 32'hA0;
      r1_req = 1; r1_addr = 32'hB0;
      #1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         #1;
         exp_o = (c <= 4 || c >= 9) ? 2'b01 : 2'b10;
         exp_a = (exp_o == 2'b01) ? 32'hA0 : 32'hB0;
         checks++;
         if (owner !== exp_o || mem_addr !== exp_a || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL hold c%0d: got o=%b a=%h rd=%b want %b %h 1",
                     c, owner, mem_addr, mem_rd, exp_o, exp_a);
         end
         checks++;
         if ((r0_gnt & r1_gnt) !== 1'b0) begin
            errors++;
            $display("FAIL hold_overlap c%0d: got both gnt want exclusive", c);
         end
      end
      r0_req = 0;
      r1_req = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid;
      tick();
      r0_req = 1; r0_we = 0; r0_addr = 32'h30;
      mem_rdata = 32'h1234;
      #1;
      tick();
      #1;
      checks++;
      if (mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL rm_beat: got mem_rd=%b want 1", mem_rd);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, mem_rd, mem_wr, owner, r0_rvalid} !== 7'b0
          || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rm_async: got %b a=%h want 0",
                  {r0_gnt, r1_gnt, mem_rd, mem_wr, owner, r0_rvalid}, mem_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rm_rvalid: got v=%b d=%h want 0 0", r0_rvalid, r0_rdata);
      end
      r0_req = 0;
      rst_n = 1'b1;
      tick();
      r0_req = 1; r1_req = 1;
      #1;
      checks++;
      if (owner !== 2'b00) begin
         errors++;
         $display("FAIL rm_idle: got owner=%b want 00", owner);
      end
      tick();
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL rm_tie: got g=%b want 10", {r0_gnt, r1_gnt});
      end
      r0_req = 0;
      r1_req = 0;
      tick();
      tick();
   endtask

   task automatic test_stream;
      tick();
      r0_req = 1; r0_we = 0; r0_addr = 32'h0;
      #1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         r0_addr = 32'(i);
         mem_rdata = 32'(i * 7);
         #1;
         checks++;
         if (r0_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 32'(i)) begin
            errors++;
            $display("FAIL stream c%0d: got g=%b rd=%b a=%h want 1 1 %h",
                     i, r0_gnt, mem_rd, mem_addr, 32'(i));
         end
         if (i > 1) begin
            checks++;
            if (r0_rvalid !== 1'b1 || r0_rdata !== 32'((i - 1) * 7)) begin
               errors++;
               $display("FAIL stream_rdata c%0d: got v=%b d=%h want 1 %h",
                        i, r0_rvalid, r0_rdata, 32'((i - 1) * 7));
            end
         end
      end
      tick();
      r0_req = 0;
      #1;
      checks++;
      if (mem_rd !== 1'b0 || r0_rdata !== 32'd140) begin
         errors++;
         $display("FAIL stream_drop: got rd=%b d=%h want 0 8c", mem_rd, r0_rdata);
      end
      tick();
      #1;
      checks++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 32'd140) begin
         errors++;
         $display("FAIL stream_end: got v=%b d=%h want 0 8c", r0_rvalid, r0_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_r0_read();
      test_r1_write();
      test_handover();
      test_hold_limit();
      test_reset_mid();
      test_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
